// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT machine timer: register offsets, CTRL field
// positions and reset constants.
package clint_pkg;

    localparam logic [11:0] OFF_MTIME_LO    = 12'h000;
    localparam logic [11:0] OFF_MTIME_HI    = 12'h004;
    localparam logic [11:0] OFF_MTIMECMP_LO = 12'h008;
    localparam logic [11:0] OFF_MTIMECMP_HI = 12'h00C;
    localparam logic [11:0] OFF_CTRL        = 12'h010;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_PRESC_LSB = 8;
    localparam int CTRL_PRESC_MSB = 15;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_MTIMECMP_LO,
        REG_MTIMECMP_HI,
        REG_CTRL,
        REG_NONE
    } reg_sel_e;

endpackage

// File: rtl/clint_prescaler.sv
// Divides clk_i by presc+1 while enabled; tick is high on the cycle the
// counter sits at presc.
module clint_prescaler (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] presc,
    output logic       tick
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick = en && (cnt_q == presc);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr || !en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// CLINT-style machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp and
// a registered level interrupt, behind a zero-wait-state register bus.
module clint_timer #(
    parameter int DW    = 32,
    parameter int ADDRW = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sel_i,
    input  logic             we_i,
    input  logic [ADDRW-1:0] addr_i,
    input  logic [DW-1:0]    wdata_i,
    output logic [DW-1:0]    rdata_o,
    output logic             rvalid_o,
    output logic             t_intr
);

    import clint_pkg::*;

    reg_sel_e         reg_sel;
    logic [ADDRW-1:0] word_addr;
    logic             wr_en;
    logic             rd_en;
    logic             ctrl_wr;
    logic             tick;
    logic             unused_addr_bits;

    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          ctrl_en_q, ctrl_en_d;
    logic [7:0]    ctrl_presc_q, ctrl_presc_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          t_intr_q, t_intr_d;

    assign unused_addr_bits = ^addr_i[1:0];
    assign word_addr        = {addr_i[ADDRW-1:2], 2'b00};
    assign wr_en            = sel_i && we_i;
    assign rd_en            = sel_i && !we_i;
    assign ctrl_wr          = wr_en && (reg_sel == REG_CTRL);

    always_comb begin
        reg_sel = REG_NONE;
        case (word_addr)
            ADDRW'(OFF_MTIME_LO):    reg_sel = REG_MTIME_LO;
            ADDRW'(OFF_MTIME_HI):    reg_sel = REG_MTIME_HI;
            ADDRW'(OFF_MTIMECMP_LO): reg_sel = REG_MTIMECMP_LO;
            ADDRW'(OFF_MTIMECMP_HI): reg_sel = REG_MTIMECMP_HI;
            ADDRW'(OFF_CTRL):        reg_sel = REG_CTRL;
            default:                 reg_sel = REG_NONE;
        endcase
    end

    clint_prescaler u_prescaler (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (ctrl_en_q),
        .clr   (ctrl_wr),
        .presc (ctrl_presc_q),
        .tick  (tick)
    );

    // A write to either mtime half suppresses the tick on that edge entirely,
    // so the other half never sees a carry from a dropped increment.
    always_comb begin
        mtime_d      = mtime_q;
        mtimecmp_d   = mtimecmp_q;
        ctrl_en_d    = ctrl_en_q;
        ctrl_presc_d = ctrl_presc_q;
        if (wr_en && reg_sel == REG_MTIME_LO) begin
            mtime_d[31:0] = wdata_i;
        end else if (wr_en && reg_sel == REG_MTIME_HI) begin
            mtime_d[63:32] = wdata_i;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wr_en && reg_sel == REG_MTIMECMP_LO) begin
            mtimecmp_d[31:0] = wdata_i;
        end
        if (wr_en && reg_sel == REG_MTIMECMP_HI) begin
            mtimecmp_d[63:32] = wdata_i;
        end
        if (ctrl_wr) begin
            ctrl_en_d    = wdata_i[CTRL_EN_BIT];
            ctrl_presc_d = wdata_i[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
        end
    end

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rd_en;
        t_intr_d = (mtime_q >= mtimecmp_q);
        if (rd_en) begin
            case (reg_sel)
                REG_MTIME_LO:    rdata_d = mtime_q[31:0];
                REG_MTIME_HI:    rdata_d = mtime_q[63:32];
                REG_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                REG_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
                REG_CTRL:        rdata_d = {16'h0000, ctrl_presc_q, 7'b0000000, ctrl_en_q};
                default:         rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q      <= '0;
            mtimecmp_q   <= MTIMECMP_RST;
            ctrl_en_q    <= 1'b0;
            ctrl_presc_q <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            t_intr_q     <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            ctrl_en_q    <= ctrl_en_d;
            ctrl_presc_q <= ctrl_presc_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            t_intr_q     <= t_intr_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign t_intr   = t_intr_q;

endmodule
